video_timing_gen: RTL and testbench

- Source end of the parallel RGB video interface that the projector pixel pipeline consumes.
- Generates 1280x720@60 raster timing (hsync, vsync, blank) plus a selectable 8-bit RGB test pattern.
- Gives bench and bring-up an on-chip stimulus in place of the HDMI receiver.
- The top-left pixel of pattern 0 carries a per-frame counter, so downstream top-left-change detection and trigger logic see one change per frame.

---
 rtl/video_timing_gen_pkg.sv | 29 ++
 rtl/video_timing_gen_if.sv | 25 ++
 rtl/video_timing_gen_counters.sv | 76 +++++++
 rtl/video_timing_gen.sv | 133 +++++++++++++
 tb/tb_video_timing_gen.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared 720p60 timing constants and test-pattern encodings for the video timing generator.
package video_timing_gen_pkg;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int H_TOT_720P    = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;

    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    localparam int V_TOT_720P    = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

    localparam int BAR_W_720P    = 160;

    typedef enum logic [1:0] {
        PAT_GRAY  = 2'd0,
        PAT_HRAMP = 2'd1,
        PAT_VRAMP = 2'd2,
        PAT_BARS  = 2'd3
    } pat_e;

    function automatic logic [7:0] fill8(input logic bit_on);
        return bit_on ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Parallel RGB video bus from the timing generator to the pixel pipeline.
interface video_timing_gen_if;

    logic [7:0] out_red;
    logic [7:0] out_green;
    logic [7:0] out_blue;
    logic       out_hsync;
    logic       out_vsync;
    logic       out_blank;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        output out_red, out_green, out_blue,
        output out_hsync, out_vsync, out_blank,
        output frame_start, frame_cnt
    );

    modport slave (
        input out_red, out_green, out_blue,
        input out_hsync, out_vsync, out_blank,
        input frame_start, frame_cnt
    );

endinterface

// File: rtl/video_timing_gen_counters.sv
// Raster h/v counters plus combinational active/sync decode of the current counter state.
module vtg_counters
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [7:0] h_lsb_o,
    output logic [7:0] v_lsb_o,
    output logic       active_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       origin_o,
    output logic       line_end_o,
    output logic       frame_end_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOT - 1);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;

    // Disabling parks the raster at the origin so the next enabled clock starts a fresh frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end else begin
            h_cnt_d = h_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_lsb_o     = h_cnt_q[7:0];
    assign v_lsb_o     = v_cnt_q[7:0];
    assign active_o    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign hsync_o     = (h_cnt_q >= H_SYNC_ON) && (h_cnt_q < H_SYNC_OFF);
    assign vsync_o     = (v_cnt_q >= V_SYNC_ON) && (v_cnt_q < V_SYNC_OFF);
    assign origin_o    = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
    assign line_end_o  = (h_cnt_q == H_LAST);
    assign frame_end_o = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// 720p60 raster timing source with selectable test pattern; every output is registered
// one clock after the counter state it describes.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter int BAR_W    = BAR_W_720P
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            pat_sel,
    video_timing_gen_if.master    vid
);

    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

    logic [7:0]  h_lsb, v_lsb;
    logic        active, hsync, vsync, origin, line_end, frame_end;

    logic [7:0]  frame_cnt_q, frame_cnt_d;
    pat_e        pat_q, pat_d, pat_cur;
    logic [10:0] bar_px_q, bar_px_d;
    logic [2:0]  bar_q, bar_d;
    logic [23:0] pix;
    logic [23:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        blank_q, blank_d, fs_q, fs_d;

    vtg_counters #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_counters (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .h_lsb_o     (h_lsb),
        .v_lsb_o     (v_lsb),
        .active_o    (active),
        .hsync_o     (hsync),
        .vsync_o     (vsync),
        .origin_o    (origin),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    // Bar index tracks h_cnt/BAR_W incrementally so the colour bars need no divider.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        bar_px_d    = '0;
        bar_d       = '0;
        if (en) begin
            if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
            if (origin)    pat_d = pat_e'(pat_sel);
            if (line_end) begin
                bar_px_d = '0;
                bar_d    = '0;
            end else if (bar_px_q == BAR_LAST) begin
                bar_px_d = '0;
                bar_d    = bar_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + 11'd1;
                bar_d    = bar_q;
            end
        end
    end

    // Pixel (0,0) is decoded on the same edge that latches pat_sel, so it bypasses pat_q.
    always_comb begin
        pat_cur = origin ? pat_e'(pat_sel) : pat_q;
        case (pat_cur)
            PAT_GRAY:  pix = {3{frame_cnt_q}};
            PAT_HRAMP: pix = {3{h_lsb}};
            PAT_VRAMP: pix = {3{v_lsb}};
            PAT_BARS:  pix = {fill8(bar_q[2]), fill8(bar_q[1]), fill8(bar_q[0])};
            default:   pix = '0;
        endcase
        rgb_d   = '0;
        hsync_d = 1'b0;
        vsync_d = 1'b0;
        blank_d = 1'b1;
        fs_d    = 1'b0;
        if (en) begin
            rgb_d   = active ? pix : 24'h0;
            hsync_d = hsync;
            vsync_d = vsync;
            blank_d = ~active;
            fs_d    = origin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            pat_q       <= PAT_GRAY;
            bar_px_q    <= '0;
            bar_q       <= '0;
            rgb_q       <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            blank_q     <= 1'b1;
            fs_q        <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            bar_px_q    <= bar_px_d;
            bar_q       <= bar_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            fs_q        <= fs_d;
        end
    end

    assign vid.out_red     = rgb_q[23:16];
    assign vid.out_green   = rgb_q[15:8];
    assign vid.out_blue    = rgb_q[7:0];
    assign vid.out_hsync   = hsync_q;
    assign vid.out_vsync   = vsync_q;
    assign vid.out_blank   = blank_q;
    assign vid.frame_start = fs_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a shrunken raster so many frames fit in a short run.
module tb_video_timing_gen;

    localparam int HA  = 32;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int VA  = 2;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int BW  = 4;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;

    typedef logic [35:0] vec_t;
    // {red, green, blue, hsync, vsync, blank, frame_start, frame_cnt}
    localparam vec_t RESET_VEC = 36'h000000200;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       en      = 1'b0;
    logic [1:0] pat_sel = 2'd0;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .BAR_W    (BW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pat_sel (pat_sel),
        .vid     (vif)
    );

    always #5 clk = ~clk;

    vec_t       expQ[$];
    logic [7:0] topLeft[$];
    int vectors = 0;
    int miscompares = 0;
    int mH = 0, mV = 0, mFrame = 0, mPat = 0;
    int hsSeen = 0, vsSeen = 0, fsSeen = 0;

    function automatic vec_t observe();
        return {vif.out_red, vif.out_green, vif.out_blue, vif.out_hsync, vif.out_vsync,
                vif.out_blank, vif.frame_start, vif.frame_cnt};
    endfunction

    task automatic checkOutput(input string tag, input vec_t got, input vec_t want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model predicts the registered outputs for the current raster state, then advances.
    task automatic applyStimulus();
        vec_t        want;
        logic [23:0] rgb;
        logic [2:0]  bar;
        logic [7:0]  lvl;
        logic        act, hs, vs, org;
        int          p;
        if (!rst_n) begin
            mH = 0; mV = 0; mFrame = 0; mPat = 0;
            want = RESET_VEC;
        end else if (!en) begin
            mH = 0; mV = 0;
            want = {24'h0, 4'b0010, 8'(mFrame)};
        end else begin
            act = (mH < HA) && (mV < VA);
            hs  = (mH >= HA + HFP) && (mH < HA + HFP + HSW);
            vs  = (mV >= VA + VFP) && (mV < VA + VFP + VSW);
            org = (mH == 0) && (mV == 0);
            p   = org ? int'(pat_sel) : mPat;
            bar = 3'(mH / BW);
            case (p)
                0:       lvl = 8'(mFrame);
                1:       lvl = 8'(mH);
                2:       lvl = 8'(mV);
                default: lvl = 8'h00;
            endcase
            rgb = (p == 3) ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : {lvl, lvl, lvl};
            if (!act) rgb = 24'h0;
            if (mH == HT - 1 && mV == VT - 1) mFrame = (mFrame + 1) % 256;
            if (org) mPat = p;
            mH++;
            if (mH == HT) begin
                mH = 0;
                mV = (mV + 1) % VT;
            end
            want = {rgb, hs, vs, ~act, org, 8'(mFrame)};
        end
        expQ.push_back(want);
        @(posedge clk);
        #1;
        checkOutput("pixel", observe(), expQ.pop_front());
        hsSeen += int'(vif.out_hsync);
        vsSeen += int'(vif.out_vsync);
        fsSeen += int'(vif.frame_start);
        if (vif.frame_start) topLeft.push_back(vif.out_red);
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_state", observe(), RESET_VEC);
        applyStimulus();

        rst_n = 1'b1;
        en = 1'b1;
        pat_sel = 2'd0;
        hsSeen = 0; vsSeen = 0; fsSeen = 0;
        applyStimulus();
        checkOutput("first_unblank", {35'd0, vif.out_blank}, 36'd0);
        runTicks(2 * FT - 1);
        checkOutput("hsync_clocks", 36'(hsSeen), 36'(2 * VT * HSW));
        checkOutput("vsync_clocks", 36'(vsSeen), 36'(2 * VSW * HT));
        checkOutput("frame_start_count", 36'(fsSeen), 36'd2);
        checkOutput("frame_cnt_two", {28'd0, vif.frame_cnt}, 36'd2);

        runTicks(2 * FT);
        checkOutput("top_left_count", 36'(topLeft.size()), 36'd4);
        for (int k = 0; k < 4 && k < topLeft.size(); k++)
            checkOutput("top_left_gray", {28'd0, topLeft[k]}, 36'(k));

        pat_sel = 2'd3;
        applyStimulus();
        checkOutput("bar0", {12'd0, vif.out_red, vif.out_green, vif.out_blue}, 36'h000000);
        runTicks(BW);
        checkOutput("bar1", {12'd0, vif.out_red, vif.out_green, vif.out_blue}, 36'h0000FF);
        runTicks(HA - 1 - BW);
        checkOutput("bar7", {12'd0, vif.out_red, vif.out_green, vif.out_blue}, 36'hFFFFFF);
        runTicks(HT - HA);
        pat_sel = 2'd1;
        runTicks(FT - HT);
        applyStimulus();
        checkOutput("hramp_px0", {12'd0, vif.out_red, vif.out_green, vif.out_blue}, 36'h000000);
        runTicks(20);
        checkOutput("hramp_px20", {12'd0, vif.out_red, vif.out_green, vif.out_blue}, 36'h141414);
        runTicks(FT - 21);

        pat_sel = 2'd2;
        runTicks(FT);

        pat_sel = 2'd0;
        for (int f = 0; f < 300 && mFrame != 0; f++) runTicks(FT);
        checkOutput("frame_cnt_wrap", {28'd0, vif.frame_cnt}, 36'd0);
        applyStimulus();
        checkOutput("wrap_top_left", {27'd0, vif.frame_start, vif.out_red}, 36'h100);
        runTicks(FT - 1);

        runTicks(HT + 5);
        en = 1'b0;
        applyStimulus();
        checkOutput("en_drop_blank", {35'd0, vif.out_blank}, 36'd1);
        runTicks(3);
        en = 1'b1;
        applyStimulus();
        checkOutput("restart_origin", {27'd0, vif.frame_start, vif.frame_cnt}, 36'h101);
        runTicks(HT + 7);

        #3 rst_n = 1'b0;
        #1 checkOutput("async_reset", observe(), RESET_VEC);
        applyStimulus();
        rst_n = 1'b1;
        runTicks(HT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
